pic_smoke_harness: RTL and testbench



---
 rtl/pic_smoke_harness.sv | 134 +++++++++++++
 tb/tb_pic_smoke_harness.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_smoke_harness.sv
// rtl/pic_smoke_harness.sv - single-cycle PIC14-subset core with program ROM and 32-byte file space
`timescale 1ns/1ps
module pic_smoke_harness #(
    parameter string ROM_FILE   = "",
    parameter int    ROM_DEPTH  = 256,
    parameter int    FILE_DEPTH = 32
) (
    input logic clk,
    input logic reset
);
    localparam int PC_W = $clog2(ROM_DEPTH);
    localparam int FA_W = $clog2(FILE_DEPTH);

    logic [13:0]     rom [ROM_DEPTH];
    logic [PC_W-1:0] pc;
    logic [7:0]      w;
    logic            z;
    logic [7:0]      file [FILE_DEPTH];
    logic [7:0]      portb;
    logic            halted;
    logic [31:0]     cycles;
    logic            flush;
    // set when the flushed cycle stands in for a skipped word and must step past it
    logic            flush_adv;

    logic [13:0]     instr;
    logic [FA_W-1:0] f_addr;
    logic [7:0]      f_val;
    logic [7:0]      f_inc;
    logic [7:0]      f_dec;
    logic [7:0]      k_sum;
    logic [PC_W-1:0] pc_inc;

    logic [PC_W-1:0] pc_nxt;
    logic [7:0]      w_nxt;
    logic            z_nxt;
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            flush_nxt;
    logic            adv_nxt;
    logic            halt_nxt;

    initial begin
        for (int i = 0; i < ROM_DEPTH; i++) rom[i] = '0;
    end

    assign instr  = rom[pc];
    assign f_addr = instr[FA_W-1:0];
    assign f_val  = file[f_addr];
    assign f_inc  = f_val + 8'd1;
    assign f_dec  = f_val - 8'd1;
    assign k_sum  = w + instr[7:0];
    assign pc_inc = (pc == PC_W'(ROM_DEPTH - 1)) ? '0 : pc + 1'b1;
    assign portb  = file[6];

    always_comb begin
        pc_nxt    = pc_inc;
        w_nxt     = w;
        z_nxt     = z;
        wr_en     = 1'b0;
        wr_data   = '0;
        flush_nxt = 1'b0;
        adv_nxt   = 1'b0;
        halt_nxt  = 1'b0;
        if (flush) begin
            pc_nxt = flush_adv ? pc_inc : pc;
        end else begin
            casez (instr)
                14'b11_00??_????_????: w_nxt = instr[7:0];
                14'b11_111?_????_????: begin
                    w_nxt = k_sum;
                    z_nxt = (k_sum == 8'd0);
                end
                14'b00_0000_1???_????: begin
                    wr_en   = 1'b1;
                    wr_data = w;
                end
                14'b00_0001_1???_????: begin
                    wr_en = 1'b1;
                    z_nxt = 1'b1;
                end
                14'b00_1010_????_????: begin
                    z_nxt = (f_inc == 8'd0);
                    if (instr[7]) begin
                        wr_en   = 1'b1;
                        wr_data = f_inc;
                    end else begin
                        w_nxt = f_inc;
                    end
                end
                14'b00_1011_????_????: begin
                    if (instr[7]) begin
                        wr_en   = 1'b1;
                        wr_data = f_dec;
                    end else begin
                        w_nxt = f_dec;
                    end
                    if (f_dec == 8'd0) begin
                        flush_nxt = 1'b1;
                        adv_nxt   = 1'b1;
                    end
                end
                14'b10_1???_????_????: begin
                    pc_nxt    = instr[PC_W-1:0];
                    flush_nxt = 1'b1;
                    halt_nxt  = (instr[PC_W-1:0] == pc);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= '0;
            w         <= '0;
            z         <= 1'b0;
            halted    <= 1'b0;
            cycles    <= '0;
            flush     <= 1'b0;
            flush_adv <= 1'b0;
            for (int i = 0; i < FILE_DEPTH; i++) file[i] <= '0;
        end else if (!halted) begin
            pc        <= pc_nxt;
            w         <= w_nxt;
            z         <= z_nxt;
            flush     <= flush_nxt;
            flush_adv <= adv_nxt;
            halted    <= halt_nxt;
            cycles    <= cycles + 32'd1;
            if (wr_en) file[f_addr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_pic_smoke_harness.sv
// tb/tb_pic_smoke_harness.sv - scoreboard bench for the PIC14-subset smoke harness
`timescale 1ns/1ps
module tb_pic_smoke_harness;
    localparam int S_PC = 0, S_W = 1, S_Z = 2, S_HALT = 3, S_CYC = 4, S_PORTB = 5, S_FILE = 6;

    typedef struct {
        string       name;
        int          sel;
        int          idx;
        logic [31:0] exp;
    } chk_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic chk_req = 1'b0;
    chk_t sb[$];
    int   total = 0;
    int   bad = 0;

    pic_smoke_harness dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] probe(input int sel, input int idx);
        logic [4:0] a;
        a = idx[4:0];
        case (sel)
            S_PC:    return {24'd0, dut.pc};
            S_W:     return {24'd0, dut.w};
            S_Z:     return {31'd0, dut.z};
            S_HALT:  return {31'd0, dut.halted};
            S_CYC:   return dut.cycles;
            S_PORTB: return {24'd0, dut.portb};
            default: return {24'd0, dut.file[a]};
        endcase
    endfunction

    // monitor: drains the scoreboard whenever the stimulus side asks for a sample
    initial begin
        forever begin
            @(chk_req);
            while (sb.size() > 0) begin
                chk_t c;
                logic [31:0] got;
                c = sb.pop_front();
                got = probe(c.sel, c.idx);
                total++;
                if (got !== c.exp) begin
                    bad++;
                    $display("FAIL %s: got %0h expected %0h", c.name, got, c.exp);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input int idx, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.idx  = idx;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    task automatic sample();
        chk_req = ~chk_req;
        #0.1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL monitor_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) dut.rom[i[7:0]] = 14'h0000;
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load_loop();
        clear_rom();
        dut.rom[0] = 14'h3003;
        dut.rom[1] = 14'h0088;
        dut.rom[2] = 14'h0B88;
        dut.rom[3] = 14'h2802;
        dut.rom[4] = 14'h2804;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // empty ROM: every word is NOP
        reset = 1'b0;
        clear_rom();
        run(3);
        expect_val("rst_pc", S_PC, 0, 32'd0);
        expect_val("rst_w", S_W, 0, 32'd0);
        expect_val("rst_z", S_Z, 0, 32'd0);
        expect_val("rst_halt", S_HALT, 0, 32'd0);
        expect_val("rst_cyc", S_CYC, 0, 32'd0);
        sample();
        @(negedge clk);
        reset = 1'b1;
        run(10);
        expect_val("nop_pc", S_PC, 0, 32'd10);
        expect_val("nop_w", S_W, 0, 32'd0);
        expect_val("nop_z", S_Z, 0, 32'd0);
        expect_val("nop_halt", S_HALT, 0, 32'd0);
        expect_val("nop_cyc", S_CYC, 0, 32'd10);
        sample();
        run(246);
        expect_val("wrap_pc", S_PC, 0, 32'd0);
        expect_val("wrap_cyc", S_CYC, 0, 32'd256);
        sample();

        // MOVLW 0x5A; MOVWF 6; GOTO 2
        reset = 1'b0;
        clear_rom();
        dut.rom[0] = 14'h305A;
        dut.rom[1] = 14'h0086;
        dut.rom[2] = 14'h2802;
        release_reset();
        run(3);
        expect_val("halt_portb", S_PORTB, 0, 32'h5A);
        expect_val("halt_flag", S_HALT, 0, 32'd1);
        sample();
        run(5);
        expect_val("frozen_pc", S_PC, 0, 32'd2);
        expect_val("frozen_cyc", S_CYC, 0, 32'd3);
        expect_val("frozen_w", S_W, 0, 32'h5A);
        sample();

        // ADDLW wrap to zero, INCF to W, INCF to file
        reset = 1'b0;
        clear_rom();
        dut.rom[0] = 14'h30FF;
        dut.rom[1] = 14'h3E01;
        dut.rom[2] = 14'h3010;
        dut.rom[3] = 14'h0086;
        dut.rom[4] = 14'h0A06;
        dut.rom[5] = 14'h0A86;
        dut.rom[6] = 14'h2806;
        release_reset();
        run(2);
        expect_val("addlw_w", S_W, 0, 32'h00);
        expect_val("addlw_z", S_Z, 0, 32'd1);
        sample();
        run(3);
        expect_val("incf_w", S_W, 0, 32'h11);
        expect_val("incf_z", S_Z, 0, 32'd0);
        expect_val("incf_f6", S_FILE, 6, 32'h10);
        expect_val("incf_pc", S_PC, 0, 32'd5);
        sample();
        run(1);
        expect_val("incfd_f6", S_FILE, 6, 32'h11);
        expect_val("incfd_w", S_W, 0, 32'h11);
        sample();

        // DECFSZ loop: 11 cycles to halt at pc=4
        reset = 1'b0;
        load_loop();
        release_reset();
        run(10);
        expect_val("loop_pc10", S_PC, 0, 32'd4);
        expect_val("loop_halt10", S_HALT, 0, 32'd0);
        expect_val("loop_f8", S_FILE, 8, 32'd0);
        sample();
        run(1);
        expect_val("loop_halt", S_HALT, 0, 32'd1);
        expect_val("loop_pc", S_PC, 0, 32'd4);
        expect_val("loop_cyc", S_CYC, 0, 32'd11);
        expect_val("loop_w", S_W, 0, 32'd3);
        sample();
        run(3);
        expect_val("loop_cyc_frz", S_CYC, 0, 32'd11);
        sample();

        // async reset pulse between edges mid-loop, then rerun
        reset = 1'b0;
        load_loop();
        release_reset();
        run(5);
        expect_val("mid_pc", S_PC, 0, 32'd2);
        expect_val("mid_w", S_W, 0, 32'd3);
        expect_val("mid_f8", S_FILE, 8, 32'd2);
        expect_val("mid_cyc", S_CYC, 0, 32'd5);
        sample();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #0.5;
        expect_val("pulse_pc", S_PC, 0, 32'd0);
        expect_val("pulse_w", S_W, 0, 32'd0);
        expect_val("pulse_f8", S_FILE, 8, 32'd0);
        expect_val("pulse_cyc", S_CYC, 0, 32'd0);
        sample();
        #0.4;
        reset = 1'b1;
        run(11);
        expect_val("rerun_halt", S_HALT, 0, 32'd1);
        expect_val("rerun_pc", S_PC, 0, 32'd4);
        expect_val("rerun_f8", S_FILE, 8, 32'd0);
        expect_val("rerun_cyc", S_CYC, 0, 32'd11);
        expect_val("rerun_w", S_W, 0, 32'd3);
        sample();

        // unused opcode as NOP, 3FFF as ADDLW 0xFF, CLRF with upper f bits set
        reset = 1'b0;
        clear_rom();
        dut.rom[0] = 14'h305A;
        dut.rom[1] = 14'h0086;
        dut.rom[2] = 14'h1FFF;
        dut.rom[3] = 14'h3FFF;
        dut.rom[4] = 14'h01A6;
        dut.rom[5] = 14'h2805;
        release_reset();
        run(3);
        expect_val("unused_pc", S_PC, 0, 32'd3);
        expect_val("unused_w", S_W, 0, 32'h5A);
        expect_val("unused_portb", S_PORTB, 0, 32'h5A);
        sample();
        run(1);
        expect_val("x3fff_w", S_W, 0, 32'h59);
        expect_val("x3fff_z", S_Z, 0, 32'd0);
        sample();
        run(1);
        expect_val("clrf_portb", S_PORTB, 0, 32'd0);
        expect_val("clrf_z", S_Z, 0, 32'd1);
        expect_val("clrf_pc", S_PC, 0, 32'd5);
        sample();
        run(1);
        expect_val("var_halt", S_HALT, 0, 32'd1);
        expect_val("var_cyc", S_CYC, 0, 32'd6);
        sample();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
